// File: rtl/key_filter.sv
// Multi-key push-button front end: per key, a 2-flop synchroniser and a debounce FSM
// that yields a debounced level plus one-cycle press, release and long-press pulses.
module key_filter #(
    parameter int          KEY_NUM  = 4,
    parameter logic [19:0] CNT_MAX  = 20'd999_999,
    parameter logic [25:0] LONG_MAX = 26'd49_999_999
) (
    input  logic               sys_clock,
    input  logic               sys_rst_n,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_level,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILT_DN = 2'd1,
        DOWN    = 2'd2,
        FILT_UP = 2'd3
    } state_t;

    // Synchroniser flops reset to 1 so a reset never looks like a press.
    logic [KEY_NUM-1:0] sync_a;
    logic [KEY_NUM-1:0] sync;

    always_ff @(posedge sys_clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_a <= '1;
            sync   <= '1;
        end else begin
            sync_a <= key_in;
            sync   <= sync_a;
        end
    end

    genvar i;
    for (i = 0; i < KEY_NUM; i++) begin : ch
        state_t      state, state_nxt;
        logic [19:0] cnt, cnt_nxt;
        logic [25:0] hold, hold_nxt;
        logic        level_q, press_q, release_q, long_q;
        logic        level_nxt, press_nxt, release_nxt, long_nxt;

        always_comb begin
            state_nxt   = state;
            cnt_nxt     = cnt;
            hold_nxt    = hold;
            level_nxt   = level_q;
            press_nxt   = 1'b0;
            release_nxt = 1'b0;
            long_nxt    = 1'b0;
            case (state)
                IDLE: begin
                    if (!sync[i]) begin
                        state_nxt = FILT_DN;
                        cnt_nxt   = '0;
                    end
                end
                FILT_DN: begin
                    if (sync[i]) begin
                        state_nxt = IDLE;
                    end else if (cnt < CNT_MAX) begin
                        cnt_nxt = cnt + 20'd1;
                    end else begin
                        state_nxt = DOWN;
                        press_nxt = 1'b1;
                        level_nxt = 1'b1;
                        hold_nxt  = '0;
                    end
                end
                DOWN: begin
                    if (sync[i]) begin
                        state_nxt = FILT_UP;
                        cnt_nxt   = '0;
                    end else if (hold < LONG_MAX) begin
                        // Long press fires only on the increment that reaches LONG_MAX, then hold saturates.
                        hold_nxt = hold + 26'd1;
                        long_nxt = (hold_nxt == LONG_MAX);
                    end
                end
                FILT_UP: begin
                    if (!sync[i]) begin
                        state_nxt = DOWN;
                    end else if (cnt < CNT_MAX) begin
                        cnt_nxt = cnt + 20'd1;
                    end else begin
                        state_nxt   = IDLE;
                        release_nxt = 1'b1;
                        level_nxt   = 1'b0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        always_ff @(posedge sys_clock or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                state     <= IDLE;
                cnt       <= '0;
                hold      <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                state     <= state_nxt;
                cnt       <= cnt_nxt;
                hold      <= hold_nxt;
                level_q   <= level_nxt;
                press_q   <= press_nxt;
                release_q <= release_nxt;
                long_q    <= long_nxt;
            end
        end

        assign key_level[i]   = level_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;
        assign key_long[i]    = long_q;
    end

endmodule

// File: tb/tb_key_filter.sv
// Bench for key_filter: directed scenarios plus random key activity, checked every cycle
// against a run-length model of the debounce rules.
module tb_key_filter;
    localparam int KN = 4;
    localparam int C  = 9;
    localparam int L  = 50;

    logic          sys_clock = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic [KN-1:0] key_in    = '1;
    logic [KN-1:0] key_level, key_press, key_release, key_long;

    always #5 sys_clock = ~sys_clock;

    key_filter #(.KEY_NUM(KN), .CNT_MAX(20'd9), .LONG_MAX(26'd50)) dut (
        .sys_clock  (sys_clock),
        .sys_rst_n  (sys_rst_n),
        .key_in     (key_in),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: what the key filter sees is key_in delayed by two edges.
    logic [KN-1:0] d0, d1;
    logic [KN-1:0] m_level, m_press, m_rel, m_long, m_prev;
    int lowrun [KN];
    int highrun[KN];
    int hold   [KN];

    // Pulse trackers filled from the DUT outputs, checked against fixed latencies.
    int press_cnt[KN], rel_cnt[KN], long_cnt[KN];
    int press_cyc[KN], rel_cyc[KN], long_cyc[KN];
    int sim_press, sim_rel;

    task automatic cmp(input string tag, input logic [KN-1:0] got, input logic [KN-1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic cmp_int(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        d0 = '1; d1 = '1;
        m_level = '0; m_press = '0; m_rel = '0; m_long = '0; m_prev = '1;
        for (int k = 0; k < KN; k++) begin
            lowrun[k] = 0; highrun[k] = 0; hold[k] = 0;
        end
    endtask

    // A key is pressed once it has been seen low C+2 edges in a row, released after C+2
    // highs in a row; hold counts low samples that directly follow a low sample while pressed.
    task automatic model_edge(input logic [KN-1:0] kin);
        logic [KN-1:0] s;
        s  = d0;
        d0 = d1;
        d1 = kin;
        m_press = '0; m_rel = '0; m_long = '0;
        for (int k = 0; k < KN; k++) begin
            if (!s[k]) begin lowrun[k]++; highrun[k] = 0; end
            else begin highrun[k]++; lowrun[k] = 0; end
            if (!m_level[k]) begin
                if (lowrun[k] == C + 2) begin
                    m_press[k] = 1'b1; m_level[k] = 1'b1; hold[k] = 0;
                end
            end else begin
                if (!s[k] && !m_prev[k] && hold[k] < L) begin
                    hold[k]++;
                    if (hold[k] == L) m_long[k] = 1'b1;
                end
                if (highrun[k] == C + 2) begin
                    m_rel[k] = 1'b1; m_level[k] = 1'b0;
                end
            end
            m_prev[k] = s[k];
        end
    endtask

    task automatic clear_trk();
        for (int k = 0; k < KN; k++) begin
            press_cnt[k] = 0; rel_cnt[k] = 0; long_cnt[k] = 0;
            press_cyc[k] = -1; rel_cyc[k] = -1; long_cyc[k] = -1;
        end
        sim_press = 0; sim_rel = 0;
    endtask

    task automatic tick(input logic [KN-1:0] kin);
        key_in = kin;
        @(posedge sys_clock);
        cyc++;
        model_edge(kin);
        #1;
        cmp("level",   key_level,   m_level);
        cmp("press",   key_press,   m_press);
        cmp("release", key_release, m_rel);
        cmp("long",    key_long,    m_long);
        cmp("exclusive", (key_press & key_long) | (key_press & key_release) | (key_long & key_release), '0);
        for (int k = 0; k < KN; k++) begin
            if (key_press[k])   begin press_cnt[k]++; press_cyc[k] = cyc; end
            if (key_release[k]) begin rel_cnt[k]++;   rel_cyc[k]   = cyc; end
            if (key_long[k])    begin long_cnt[k]++;  long_cyc[k]  = cyc; end
        end
        if (key_press == 4'hF)   sim_press++;
        if (key_release == 4'hF) sim_rel++;
    endtask

    task automatic ticks(input int n, input logic [KN-1:0] kin);
        for (int j = 0; j < n; j++) tick(kin);
    endtask

    // Called just after a tick: reset asserts mid-cycle, outputs must clear at once.
    task automatic do_reset();
        #2 sys_rst_n = 1'b0;
        #1;
        cmp("rst_level",   key_level,   '0);
        cmp("rst_press",   key_press,   '0);
        cmp("rst_release", key_release, '0);
        cmp("rst_long",    key_long,    '0);
        model_reset();
        @(posedge sys_clock);
        #1 sys_rst_n = 1'b1;
    endtask

    initial begin
        int start;
        logic [KN-1:0] rv;
        int rem[KN];

        model_reset();
        clear_trk();
        repeat (2) @(posedge sys_clock);
        #1;
        cmp("reset_level",   key_level,   '0);
        cmp("reset_press",   key_press,   '0);
        cmp("reset_release", key_release, '0);
        cmp("reset_long",    key_long,    '0);
        sys_rst_n = 1'b1;

        // Clean press on key 0.
        clear_trk();
        start = cyc + 1;
        ticks(15, 4'b1110);
        cmp_int("clean_press_cnt", press_cnt[0], 1);
        cmp_int("clean_press_edge", press_cyc[0], start + 12);
        cmp("clean_level", key_level, 4'b0001);

        // Hold until long fires, then release with a 4-cycle low glitch.
        ticks(50, 4'b1110);
        cmp_int("k0_long_cnt", long_cnt[0], 1);
        cmp_int("k0_long_edge", long_cyc[0], start + 12 + L);
        clear_trk();
        ticks(2, 4'b1111);
        ticks(4, 4'b1110);
        start = cyc + 1;
        ticks(20, 4'b1111);
        cmp_int("rel_bounce_cnt", rel_cnt[0], 1);
        cmp_int("rel_bounce_edge", rel_cyc[0], start + 12);
        cmp_int("rel_no_relong", long_cnt[0], 0);

        // Bounce rejection on key 1.
        clear_trk();
        for (int r = 0; r < 4; r++) begin
            ticks(5, 4'b1101);
            ticks(3, 4'b1111);
        end
        ticks(20, 4'b1111);
        cmp_int("bounce_press", press_cnt[1], 0);
        cmp_int("bounce_release", rel_cnt[1], 0);
        cmp("bounce_level", key_level, 4'b0000);

        // Long press on key 2.
        clear_trk();
        ticks(100, 4'b1011);
        cmp_int("long_press_cnt", press_cnt[2], 1);
        cmp_int("long_cnt", long_cnt[2], 1);
        cmp_int("long_edge", long_cyc[2], press_cyc[2] + L);
        ticks(20, 4'b1111);

        // Simultaneous press and release on all keys.
        clear_trk();
        ticks(20, 4'b0000);
        ticks(20, 4'b1111);
        cmp_int("sim_press", sim_press, 1);
        cmp_int("sim_release", sim_rel, 1);

        // Reset while key 3 is filtering down, then while it is down.
        ticks(5, 4'b0111);
        do_reset();
        clear_trk();
        start = cyc + 1;
        ticks(15, 4'b0111);
        cmp_int("rst_fd_press_edge", press_cyc[3], start + 12);
        cmp_int("rst_fd_press_cnt", press_cnt[3], 1);
        ticks(5, 4'b0111);
        do_reset();
        clear_trk();
        start = cyc + 1;
        ticks(15, 4'b0111);
        cmp_int("rst_dn_press_edge", press_cyc[3], start + 12);
        cmp_int("rst_dn_press_cnt", press_cnt[3], 1);
        ticks(20, 4'b1111);

        // Random key activity with a mix of short bounces and long holds.
        rv = '1;
        for (int k = 0; k < KN; k++) rem[k] = 0;
        for (int t = 0; t < 3000; t++) begin
            for (int k = 0; k < KN; k++) begin
                if (rem[k] == 0) begin
                    rv[k] = ~rv[k];
                    rem[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 90))
                                                          : int'($urandom_range(1, 20));
                end
                rem[k]--;
            end
            tick(rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
